// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM/WB stage (master) and the data memory (slave).
//   mem_req   : request, held high until mem_ack is sampled or the access times out
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : access address (AW bits)
//   mem_wdata : store data
//   mem_ack   : memory completes the access this cycle
//   mem_rdata : load data, valid while mem_ack = 1
interface mem_wb_stage_if #(
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack;
    logic [15:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: consumes the EX/MEM buffer, runs the data-memory
// handshake for loads/stores and presents a registered writeback bundle plus a
// combinational forwarding copy.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   valid_in, op_in   : EX/MEM instruction valid, op (00 ALU, 01 load, 10 store, 11 NOP)
//   rd_in, alu_in     : destination register, ALU result / memory address
//   data_in, r0_in    : store data, R0 side value
//   flush             : kills the instruction currently in this stage
//   stall             : upstream must hold EX/MEM while a memory access is pending
//   bus               : data-memory master port (see mem_wb_stage_if)
//   wb_*              : registered writeback bundle, single-cycle wb_valid pulse
//   fwd_*             : forwarding copy of wb_we / wb_rd / wb_data
//   err               : sticky, set when an access times out
//
// state  | meaning
// IDLE   | accepting instructions; ALU/NOP retire one cycle after accept
// ACCESS | memory request outstanding; upstream stalled
module mem_wb_stage #(
    parameter int TIMEOUT = 15,
    parameter int AW      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [1:0]           op_in,
    input  logic [3:0]           rd_in,
    input  logic [15:0]          alu_in,
    input  logic [15:0]          data_in,
    input  logic [15:0]          r0_in,
    input  logic                 flush,
    output logic                 stall,
    mem_wb_stage_if.master       bus,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [3:0]           wb_rd,
    output logic [15:0]          wb_data,
    output logic [15:0]          wb_r0,
    output logic                 fwd_valid,
    output logic [3:0]           fwd_rd,
    output logic [15:0]          fwd_data,
    output logic                 err
);

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [7:0]    cnt, cnt_nxt, cnt_inc;
    logic          kill, kill_nxt;
    logic [3:0]    rd_lat, rd_lat_nxt;
    logic [15:0]   r0_lat, r0_lat_nxt;
    logic          req_nxt, we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [15:0]   wdata_nxt;
    logic          wb_valid_nxt, wb_we_nxt;
    logic [3:0]    wb_rd_nxt;
    logic [15:0]   wb_data_nxt, wb_r0_nxt;
    logic          err_nxt;

    assign cnt_inc = cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            kill          <= 1'b0;
            rd_lat        <= '0;
            r0_lat        <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_we         <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_r0         <= '0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            kill          <= kill_nxt;
            rd_lat        <= rd_lat_nxt;
            r0_lat        <= r0_lat_nxt;
            bus.mem_req   <= req_nxt;
            bus.mem_we    <= we_nxt;
            bus.mem_addr  <= addr_nxt;
            bus.mem_wdata <= wdata_nxt;
            wb_valid      <= wb_valid_nxt;
            wb_we         <= wb_we_nxt;
            wb_rd         <= wb_rd_nxt;
            wb_data       <= wb_data_nxt;
            wb_r0         <= wb_r0_nxt;
            err           <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        kill_nxt     = kill;
        rd_lat_nxt   = rd_lat;
        r0_lat_nxt   = r0_lat;
        req_nxt      = bus.mem_req;
        we_nxt       = bus.mem_we;
        addr_nxt     = bus.mem_addr;
        wdata_nxt    = bus.mem_wdata;
        wb_valid_nxt = 1'b0;
        wb_we_nxt    = 1'b0;
        wb_rd_nxt    = wb_rd;
        wb_data_nxt  = wb_data;
        wb_r0_nxt    = wb_r0;
        err_nxt      = err;

        case (state)
            IDLE: begin
                if (valid_in && !flush) begin
                    case (op_in)
                        OP_ALU: begin
                            wb_valid_nxt = 1'b1;
                            wb_we_nxt    = 1'b1;
                            wb_rd_nxt    = rd_in;
                            wb_data_nxt  = alu_in;
                            wb_r0_nxt    = r0_in;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_nxt  = ACCESS;
                            req_nxt    = 1'b1;
                            we_nxt     = (op_in == OP_STORE);
                            addr_nxt   = alu_in[AW-1:0];
                            wdata_nxt  = data_in;
                            rd_lat_nxt = rd_in;
                            r0_lat_nxt = r0_in;
                            cnt_nxt    = '0;
                            kill_nxt   = 1'b0;
                        end
                        default: begin
                            wb_valid_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ACCESS: begin
                cnt_nxt = cnt_inc;
                if (flush) begin
                    kill_nxt = 1'b1;
                end
                // An ack arriving on the final allowed cycle still completes normally.
                if (bus.mem_ack || (cnt_inc == TO_CNT)) begin
                    state_nxt    = IDLE;
                    req_nxt      = 1'b0;
                    kill_nxt     = 1'b0;
                    wb_valid_nxt = 1'b1;
                    wb_rd_nxt    = rd_lat;
                    wb_r0_nxt    = r0_lat;
                    if (bus.mem_ack) begin
                        // A flush on the completing edge kills the writeback too.
                        if (!bus.mem_we && !(kill || flush)) begin
                            wb_we_nxt   = 1'b1;
                            wb_data_nxt = bus.mem_rdata;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall     = (state == ACCESS);
    assign fwd_valid = wb_we;
    assign fwd_rd    = wb_rd;
    assign fwd_data  = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [1:0]  op_in;
    logic [3:0]  rd_in;
    logic [15:0] alu_in, data_in, r0_in;
    logic        flush;
    logic        stall;
    logic        wb_valid, wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data, wb_r0;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_wb_stage_if #(.AW(16)) bus ();

    mem_wb_stage #(.TIMEOUT(15), .AW(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .op_in    (op_in),
        .rd_in    (rd_in),
        .alu_in   (alu_in),
        .data_in  (data_in),
        .r0_in    (r0_in),
        .flush    (flush),
        .stall    (stall),
        .bus      (bus),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_r0    (wb_r0),
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [3:0]  rd;
        logic [15:0] alu;
        logic [15:0] r0;
        logic        fl;
        logic        e_valid;
        logic        e_we;
        logic [3:0]  e_rd;
        logic [15:0] e_data;
        logic [15:0] e_r0;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic v, input logic we,
                          input logic [3:0] rd, input logic [15:0] data, input logic [15:0] r0);
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v));
        chk({tag, " wb_we"}, 32'(wb_we), 32'(we));
        chk({tag, " wb_rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, " wb_data"}, 32'(wb_data), 32'(data));
        chk({tag, " wb_r0"}, 32'(wb_r0), 32'(r0));
        chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(we));
        chk({tag, " fwd_rd"}, 32'(fwd_rd), 32'(rd));
        chk({tag, " fwd_data"}, 32'(fwd_data), 32'(data));
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] rd, input logic [15:0] alu,
                         input logic [15:0] data, input logic [15:0] r0);
        valid_in = 1'b1;
        op_in    = op;
        rd_in    = rd;
        alu_in   = alu;
        data_in  = data;
        r0_in    = r0;
    endtask

    initial begin
        reset = 1'b1;
        valid_in = 1'b0; op_in = 2'b00; rd_in = '0; alu_in = '0; data_in = '0; r0_in = '0;
        flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Single-cycle IDLE-path vectors, applied back to back.
        vecs[0] = '{1'b1, 2'b00, 4'd3,  16'h1234, 16'h0005, 1'b0, 1'b1, 1'b1, 4'd3,  16'h1234, 16'h0005};
        vecs[1] = '{1'b1, 2'b11, 4'd9,  16'hFFFF, 16'h0009, 1'b0, 1'b1, 1'b0, 4'd3,  16'h1234, 16'h0005};
        vecs[2] = '{1'b1, 2'b00, 4'd15, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1, 4'd15, 16'hFFFF, 16'h8000};
        vecs[3] = '{1'b1, 2'b00, 4'd2,  16'h0BAD, 16'h0002, 1'b1, 1'b0, 1'b0, 4'd15, 16'hFFFF, 16'h8000};
        vecs[4] = '{1'b0, 2'b00, 4'd1,  16'h1111, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd15, 16'hFFFF, 16'h8000};
        vecs[5] = '{1'b1, 2'b00, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd0,  16'h0000, 16'h0000};

        step();
        step();
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk_wb("rst", 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            valid_in = vecs[i].valid;
            op_in    = vecs[i].op;
            rd_in    = vecs[i].rd;
            alu_in   = vecs[i].alu;
            r0_in    = vecs[i].r0;
            flush    = vecs[i].fl;
            step();
            valid_in = 1'b0;
            flush    = 1'b0;
            chk_wb($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_we,
                   vecs[i].e_rd, vecs[i].e_data, vecs[i].e_r0);
            chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
        end
        step();

        // Load acked on the 3rd request cycle.
        issue(2'b01, 4'd7, 16'h0040, 16'h0000, 16'h0022);
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ld req c%0d", k), 32'(bus.mem_req), 32'd1);
            chk($sformatf("ld stall c%0d", k), 32'(stall), 32'd1);
            chk($sformatf("ld addr c%0d", k), 32'(bus.mem_addr), 32'h0040);
            chk($sformatf("ld we c%0d", k), 32'(bus.mem_we), 32'd0);
            chk($sformatf("ld wbv c%0d", k), 32'(wb_valid), 32'd0);
            if (k == 2) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 16'hBEEF;
            end
            step();
        end
        bus.mem_ack = 1'b0;
        chk("ld req done", 32'(bus.mem_req), 32'd0);
        chk("ld stall done", 32'(stall), 32'd0);
        chk_wb("ld", 1'b1, 1'b1, 4'd7, 16'hBEEF, 16'h0022);
        step();
        chk("ld pulse", 32'(wb_valid), 32'd0);

        // Store with immediate ack while upstream holds an ALU op.
        issue(2'b10, 4'd4, 16'h0010, 16'hA5A5, 16'h0003);
        step();
        chk("st req", 32'(bus.mem_req), 32'd1);
        chk("st we", 32'(bus.mem_we), 32'd1);
        chk("st addr", 32'(bus.mem_addr), 32'h0010);
        chk("st wdata", 32'(bus.mem_wdata), 32'hA5A5);
        chk("st stall", 32'(stall), 32'd1);
        issue(2'b00, 4'd6, 16'h5555, 16'h0000, 16'h0006);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("st stall drop", 32'(stall), 32'd0);
        chk("st req drop", 32'(bus.mem_req), 32'd0);
        chk_wb("st", 1'b1, 1'b0, 4'd4, 16'hBEEF, 16'h0003);
        step();
        valid_in = 1'b0;
        chk_wb("st alu", 1'b1, 1'b1, 4'd6, 16'h5555, 16'h0006);
        step();
        chk("st alu pulse", 32'(wb_valid), 32'd0);

        // Load that never gets acked: times out after 15 request cycles.
        issue(2'b01, 4'd5, 16'h0100, 16'h0000, 16'h0055);
        step();
        valid_in = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk($sformatf("to req c%0d", k), 32'(bus.mem_req), 32'd1);
            step();
        end
        chk("to req drop", 32'(bus.mem_req), 32'd0);
        chk("to stall", 32'(stall), 32'd0);
        chk("to err", 32'(err), 32'd1);
        chk_wb("to", 1'b1, 1'b0, 4'd5, 16'h5555, 16'h0055);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h1234;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("late ack wbv %0d", k), 32'(wb_valid), 32'd0);
            chk($sformatf("late ack data %0d", k), 32'(wb_data), 32'h5555);
            chk($sformatf("late ack req %0d", k), 32'(bus.mem_req), 32'd0);
            chk($sformatf("late ack err %0d", k), 32'(err), 32'd1);
        end
        bus.mem_ack = 1'b0;

        // Flush during a load access, ack on the 2nd request cycle.
        issue(2'b01, 4'd9, 16'h0080, 16'h0000, 16'h0099);
        step();
        valid_in = 1'b0;
        flush = 1'b1;
        chk("fl req c0", 32'(bus.mem_req), 32'd1);
        step();
        flush = 1'b0;
        chk("fl req c1", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hCAFE;
        step();
        bus.mem_ack = 1'b0;
        chk("fl wb_valid", 32'(wb_valid), 32'd1);
        chk("fl wb_we", 32'(wb_we), 32'd0);
        chk("fl fwd_valid", 32'(fwd_valid), 32'd0);
        chk("fl wb_rd", 32'(wb_rd), 32'd9);
        chk("fl stall", 32'(stall), 32'd0);
        // Next load is not killed: the kill bit was cleared on return to IDLE.
        issue(2'b01, 4'd8, 16'h0090, 16'h0000, 16'h0088);
        step();
        valid_in = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h7777;
        step();
        bus.mem_ack = 1'b0;
        chk_wb("fl next", 1'b1, 1'b1, 4'd8, 16'h7777, 16'h0088);
        issue(2'b00, 4'd11, 16'h4321, 16'h0000, 16'h0011);
        flush = 1'b1;
        step();
        valid_in = 1'b0;
        flush = 1'b0;
        chk("fl alu wbv", 32'(wb_valid), 32'd0);
        chk("fl alu rd", 32'(wb_rd), 32'd8);

        // Reset asserted on the 2nd request cycle of a load.
        issue(2'b01, 4'd12, 16'h00C0, 16'h0000, 16'h00CC);
        step();
        valid_in = 1'b0;
        step();
        chk("rm req before", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rm req", 32'(bus.mem_req), 32'd0);
        chk("rm stall", 32'(stall), 32'd0);
        chk("rm wbv", 32'(wb_valid), 32'd0);
        chk("rm err", 32'(err), 32'd0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rm post wbv %0d", k), 32'(wb_valid), 32'd0);
            chk($sformatf("rm post req %0d", k), 32'(bus.mem_req), 32'd0);
        end
        bus.mem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
